// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
// Second-generation control FSM for the simple RISC datapath. It sequences
// fetch, PC increment, decode, execute, branch, memory and writeback steps. Memory
// accesses use a variable-latency mem_ready handshake. The controller has an
// explicit HALT state and sticky illegal-instruction and memory-timeout flags.
//
// Optional feature: define MEM_TIMEOUT_EN to add the memory wait-timeout
// counter. When the macro is undefined, waits are unbounded and mem_err is 0.
//
// Parameters
//   MEM_HANDSHAKE  : 1 = memory states wait for mem_ready, 0 = zero-wait memory
//   TIMEOUT_CYCLES : consecutive wait cycles before mem_err (MEM_TIMEOUT_EN only)
//   TIMEOUT_W      : wait counter width, 2**TIMEOUT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   opcode, op, cond      : instruction fields IR[15:13], IR[12:11], IR[10:8]
//   status                : {N,V,Z} from the status register
//   mem_ready             : memory completes the current access this cycle
//   pc_reset, pc_load     : PC reset-value select and PC load
//   pc_sel                : 00 PC+1, 01 PC+1+sximm8, 10 datapath C
//   ir_load, addr_sel     : IR load, address source (1 PC, 0 data address)
//   mem_cmd               : 00 none, 01 write, 10 read
//   reg_w/a/b_sel         : one-hot register selects (100 Rn, 010 Rd, 001 Rm)
//   write, loada..loadm   : register file write, datapath register loads
//   asel, bsel, csel      : datapath input selects
//   vsel                  : writeback source (1000 PC, 0100 sximm8, 0010 mdata, 0001 C)
//   halted, illegal, mem_err : HALT indicator and sticky error flags

module cpu_ctrl_fsm #(
  parameter int MEM_HANDSHAKE  = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic [2:0] status,
  input  logic       mem_ready,
  output logic       pc_reset,
  output logic       pc_load,
  output logic [1:0] pc_sel,
  output logic       ir_load,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic [2:0] reg_w_sel,
  output logic [2:0] reg_a_sel,
  output logic [2:0] reg_b_sel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       loadm,
  output logic       asel,
  output logic       bsel,
  output logic       csel,
  output logic [3:0] vsel,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_RESET, S_IF, S_UPC, S_DECODE, S_EXEC, S_BRANCH, S_MEM, S_WRITE, S_HALT
  } state_t;

  // Instruction class remembered from DECODE so EXEC and MEM do not depend
  // on the IR fields staying stable.
  typedef enum logic [2:0] {
    K_MOVR, K_ALU, K_CMP, K_LDR, K_STR, K_BX
  } kind_t;

  typedef enum logic [3:0] {
    D_MOVI, D_MOVR, D_ALU, D_CMP, D_LDR, D_STR, D_BR, D_BL, D_BX, D_BLX,
    D_HALT, D_ILL
  } dec_t;

  state_t state;
  kind_t  kind;
  dec_t   dec;
  logic   ready;
  logic   br_taken;
  logic   br_bad;
  logic   expired;

  // This empty block is elaborated only for a wait counter that is too narrow.
  // It makes the bad configuration visible in the elaborated hierarchy.
  if ((2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_timeout_cfg_invalid
  end

  // With the handshake disabled, every access completes in its first cycle.
  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 waiting;

  // A wait cycle is an IF or MEM cycle in which memory has not responded.
  // The access expires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign waiting = ((state == S_IF) || (state == S_MEM)) && !ready;
  assign expired = waiting && (wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Instruction classification on {opcode, op}. CMP is listed before the
  // general ALU pattern so that it wins the match.
  always_comb begin
    dec = D_ILL;
    casez ({opcode, op})
      5'b110_10: dec = D_MOVI;
      5'b110_00: dec = D_MOVR;
      5'b101_01: dec = D_CMP;
      5'b101_??: dec = D_ALU;
      5'b011_00: dec = D_LDR;
      5'b100_00: dec = D_STR;
      5'b001_00: dec = D_BR;
      5'b010_11: dec = D_BL;
      5'b010_00: dec = D_BX;
      5'b010_10: dec = D_BLX;
      5'b111_??: dec = D_HALT;
      default:   dec = D_ILL;
    endcase
  end

  // Branch condition evaluation on {N,V,Z}. Condition codes 101-111 are
  // undefined, and the instruction is treated as illegal.
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = status[0];
      3'b010:  br_taken = !status[0];
      3'b011:  br_taken = status[2] ^ status[1];
      3'b100:  br_taken = (status[2] ^ status[1]) | status[0];
      default: br_bad   = 1'b1;
    endcase
  end

  // State register, remembered instruction class and sticky flags. Reset has
  // priority in every state and abandons any access that is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      kind    <= K_ALU;
      illegal <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_err  <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      if (waiting) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      else         wait_cnt <= '0;
      if (expired) mem_err <= 1'b1;
`endif
      case (state)
        S_RESET: state <= S_IF;
        S_IF: begin
          if (expired)    state <= S_HALT;
          else if (ready) state <= S_UPC;
        end
        S_UPC: state <= S_DECODE;
        S_DECODE: begin
          case (dec)
            D_MOVI, D_BL: state <= S_IF;
            D_MOVR: begin kind <= K_MOVR; state <= S_EXEC; end
            D_ALU:  begin kind <= K_ALU;  state <= S_EXEC; end
            D_CMP:  begin kind <= K_CMP;  state <= S_EXEC; end
            D_LDR:  begin kind <= K_LDR;  state <= S_EXEC; end
            D_STR:  begin kind <= K_STR;  state <= S_EXEC; end
            D_BX, D_BLX: begin kind <= K_BX; state <= S_EXEC; end
            D_BR: begin
              if (br_bad) begin
                illegal <= 1'b1;
                state   <= S_HALT;
              end else begin
                state <= S_IF;
              end
            end
            D_HALT: state <= S_HALT;
            default: begin
              illegal <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_EXEC: begin
          case (kind)
            K_CMP:        state <= S_IF;
            K_LDR, K_STR: state <= S_MEM;
            K_BX:         state <= S_BRANCH;
            default:      state <= S_WRITE;
          endcase
        end
        S_BRANCH: state <= S_IF;
        S_MEM: begin
          if (expired)    state <= S_HALT;
          else if (ready) state <= S_IF;
        end
        S_WRITE: state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Control outputs decoded from the state register. The IF, MEM and DECODE
  // outputs also use mem_ready and the IR/status fields of the current cycle.
  // This lets an access complete in the same cycle that memory responds.
  always_comb begin
    pc_reset  = 1'b0;
    pc_load   = 1'b0;
    pc_sel    = 2'b00;
    ir_load   = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = 2'b00;
    reg_w_sel = 3'b000;
    reg_a_sel = 3'b000;
    reg_b_sel = 3'b000;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    loadm     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    csel      = 1'b0;
    vsel      = 4'b0000;
    halted    = (state == S_HALT);
    case (state)
      S_RESET: begin
        pc_reset = 1'b1;
        pc_load  = 1'b1;
      end
      S_IF: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b10;
        ir_load  = ready;
      end
      S_UPC: begin
        pc_load = 1'b1;
        pc_sel  = 2'b00;
      end
      S_DECODE: begin
        case (dec)
          D_MOVI: begin
            reg_w_sel = 3'b100;
            vsel      = 4'b0100;
            write     = 1'b1;
          end
          D_MOVR: begin
            reg_b_sel = 3'b001;
            loadb     = 1'b1;
          end
          D_ALU, D_CMP: begin
            reg_a_sel = 3'b100;
            reg_b_sel = 3'b001;
            loada     = 1'b1;
            loadb     = 1'b1;
          end
          D_LDR: begin
            reg_a_sel = 3'b100;
            loada     = 1'b1;
          end
          D_STR: begin
            reg_a_sel = 3'b100;
            reg_b_sel = 3'b010;
            loada     = 1'b1;
            loadb     = 1'b1;
          end
          D_BR: begin
            if (br_taken && !br_bad) begin
              pc_load = 1'b1;
              pc_sel  = 2'b01;
            end
          end
          D_BL: begin
            reg_w_sel = 3'b100;
            vsel      = 4'b1000;
            write     = 1'b1;
            pc_load   = 1'b1;
            pc_sel    = 2'b01;
          end
          D_BX: begin
            reg_b_sel = 3'b010;
            loadb     = 1'b1;
          end
          D_BLX: begin
            // Rd is read before the link write, so loadb captures the old value
            // even when Rn and Rd name the same register.
            reg_b_sel = 3'b010;
            loadb     = 1'b1;
            reg_w_sel = 3'b100;
            vsel      = 4'b1000;
            write     = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_EXEC: begin
        case (kind)
          K_MOVR, K_BX: begin
            asel  = 1'b1;
            loadc = 1'b1;
          end
          K_CMP: loads = 1'b1;
          K_LDR: begin
            bsel  = 1'b1;
            loadm = 1'b1;
          end
          K_STR: begin
            bsel  = 1'b1;
            csel  = 1'b1;
            loadm = 1'b1;
            loadc = 1'b1;
          end
          default: loadc = 1'b1;
        endcase
      end
      S_BRANCH: begin
        pc_load = 1'b1;
        pc_sel  = 2'b10;
      end
      S_MEM: begin
        if (kind == K_LDR) begin
          addr_sel = 1'b0;
          mem_cmd  = 2'b10;
          if (ready) begin
            reg_w_sel = 3'b010;
            vsel      = 4'b0010;
            write     = 1'b1;
          end
        end else begin
          mem_cmd = 2'b01;
        end
      end
      S_WRITE: begin
        reg_w_sel = 3'b010;
        vsel      = 4'b0001;
        write     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm
// Cycle-by-cycle bench for cpu_ctrl_fsm. Each record gives the inputs for one
// clock cycle and the full set of outputs expected in that cycle. The record's
// expected outputs go into a queue when its inputs are driven. They are popped and
// compared at the following falling edge. Define MEM_TIMEOUT_EN to build the
// timeout variant, which uses TIMEOUT_CYCLES=4.

module tb_cpu_ctrl_fsm;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  localparam logic [4:0] MOVI = 5'b11010;
  localparam logic [4:0] MOVR = 5'b11000;
  localparam logic [4:0] ADD  = 5'b10100;
  localparam logic [4:0] CMP  = 5'b10101;
  localparam logic [4:0] LDR  = 5'b01100;
  localparam logic [4:0] STR  = 5'b10000;
  localparam logic [4:0] BR   = 5'b00100;
  localparam logic [4:0] BL   = 5'b01011;
  localparam logic [4:0] BX   = 5'b01000;
  localparam logic [4:0] BLX  = 5'b01010;
  localparam logic [4:0] HLT  = 5'b11100;
  localparam logic [4:0] UND  = 5'b00000;

  typedef struct packed {
    logic       pc_reset;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       ir_load;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic [2:0] reg_w_sel;
    logic [2:0] reg_a_sel;
    logic [2:0] reg_b_sel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       loadm;
    logic       asel;
    logic       bsel;
    logic       csel;
    logic [3:0] vsel;
    logic       halted;
    logic       illegal;
    logic       mem_err;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic [4:0]  inst;
    logic [2:0]  cond;
    logic [2:0]  status;
    logic        rdy;
    out_t        exp;
    logic [95:0] tag;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] cond;
  logic [2:0] status;
  logic       mem_ready;
  logic       pc_reset, pc_load, ir_load, addr_sel;
  logic [1:0] pc_sel, mem_cmd;
  logic [2:0] reg_w_sel, reg_a_sel, reg_b_sel;
  logic       write, loada, loadb, loadc, loads, loadm, asel, bsel, csel;
  logic [3:0] vsel;
  logic       halted, illegal, mem_err;
  out_t       act;

  out_t        exp_q[$];
  logic [95:0] tag_q[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;

  cpu_ctrl_fsm #(
    .MEM_HANDSHAKE (1),
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .TIMEOUT_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .op       (op),
    .cond     (cond),
    .status   (status),
    .mem_ready(mem_ready),
    .pc_reset (pc_reset),
    .pc_load  (pc_load),
    .pc_sel   (pc_sel),
    .ir_load  (ir_load),
    .addr_sel (addr_sel),
    .mem_cmd  (mem_cmd),
    .reg_w_sel(reg_w_sel),
    .reg_a_sel(reg_a_sel),
    .reg_b_sel(reg_b_sel),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .loadm    (loadm),
    .asel     (asel),
    .bsel     (bsel),
    .csel     (csel),
    .vsel     (vsel),
    .halted   (halted),
    .illegal  (illegal),
    .mem_err  (mem_err)
  );

  // The concatenation below follows the field order of out_t.
  assign act = {pc_reset, pc_load, pc_sel, ir_load, addr_sel, mem_cmd,
                reg_w_sel, reg_a_sel, reg_b_sel, write, loada, loadb, loadc,
                loads, loadm, asel, bsel, csel, vsel, halted, illegal, mem_err};

  // 10 ns clock, with rising edges at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output sets, one for each state or instruction step.
  function automatic out_t o_reset();
    out_t o = '0; o.pc_reset = 1; o.pc_load = 1; return o;
  endfunction
  function automatic out_t o_if(input logic r);
    out_t o = '0; o.addr_sel = 1; o.mem_cmd = 2'b10; o.ir_load = r; return o;
  endfunction
  function automatic out_t o_upc();
    out_t o = '0; o.pc_load = 1; o.pc_sel = 2'b00; return o;
  endfunction
  function automatic out_t o_movi();
    out_t o = '0; o.reg_w_sel = 3'b100; o.vsel = 4'b0100; o.write = 1; return o;
  endfunction
  function automatic out_t o_movr_dec();
    out_t o = '0; o.reg_b_sel = 3'b001; o.loadb = 1; return o;
  endfunction
  function automatic out_t o_alu_dec();
    out_t o = '0; o.reg_a_sel = 3'b100; o.reg_b_sel = 3'b001;
    o.loada = 1; o.loadb = 1; return o;
  endfunction
  function automatic out_t o_ldr_dec();
    out_t o = '0; o.reg_a_sel = 3'b100; o.loada = 1; return o;
  endfunction
  function automatic out_t o_str_dec();
    out_t o = '0; o.reg_a_sel = 3'b100; o.reg_b_sel = 3'b010;
    o.loada = 1; o.loadb = 1; return o;
  endfunction
  function automatic out_t o_br(input logic taken);
    out_t o = '0; o.pc_load = taken; o.pc_sel = taken ? 2'b01 : 2'b00; return o;
  endfunction
  function automatic out_t o_bl();
    out_t o = '0; o.reg_w_sel = 3'b100; o.vsel = 4'b1000; o.write = 1;
    o.pc_load = 1; o.pc_sel = 2'b01; return o;
  endfunction
  function automatic out_t o_bx_dec();
    out_t o = '0; o.reg_b_sel = 3'b010; o.loadb = 1; return o;
  endfunction
  function automatic out_t o_blx_dec();
    out_t o = '0; o.reg_b_sel = 3'b010; o.loadb = 1; o.reg_w_sel = 3'b100;
    o.vsel = 4'b1000; o.write = 1; return o;
  endfunction
  function automatic out_t o_exec_asel();
    out_t o = '0; o.asel = 1; o.loadc = 1; return o;
  endfunction
  function automatic out_t o_exec_alu();
    out_t o = '0; o.loadc = 1; return o;
  endfunction
  function automatic out_t o_exec_cmp();
    out_t o = '0; o.loads = 1; return o;
  endfunction
  function automatic out_t o_exec_ldr();
    out_t o = '0; o.bsel = 1; o.loadm = 1; return o;
  endfunction
  function automatic out_t o_exec_str();
    out_t o = '0; o.bsel = 1; o.csel = 1; o.loadm = 1; o.loadc = 1; return o;
  endfunction
  function automatic out_t o_branch();
    out_t o = '0; o.pc_load = 1; o.pc_sel = 2'b10; return o;
  endfunction
  function automatic out_t o_mem_ldr(input logic r);
    out_t o = '0; o.mem_cmd = 2'b10;
    if (r) begin o.reg_w_sel = 3'b010; o.vsel = 4'b0010; o.write = 1; end
    return o;
  endfunction
  function automatic out_t o_mem_str();
    out_t o = '0; o.mem_cmd = 2'b01; return o;
  endfunction
  function automatic out_t o_write();
    out_t o = '0; o.reg_w_sel = 3'b010; o.vsel = 4'b0001; o.write = 1; return o;
  endfunction
  function automatic out_t o_halt(input logic ill, input logic merr);
    out_t o = '0; o.halted = 1; o.illegal = ill; o.mem_err = merr; return o;
  endfunction
  function automatic out_t o_none();
    out_t o = '0; return o;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [4:0] inst,
                               input logic [2:0] c, input logic [2:0] st,
                               input logic rdy, input out_t e,
                               input logic [95:0] tag);
    vec_t v;
    v.rst = rst; v.inst = inst; v.cond = c; v.status = st; v.rdy = rdy;
    v.exp = e; v.tag = tag;
    return v;
  endfunction

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic checkOutput();
    out_t        e;
    logic [95:0] t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %0s: outputs got %h, expected %h (t=%0t)", t, act, e, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and records its
  // expectation. The comparison is made at the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset     = v.rst;
    opcode    = v.inst[4:2];
    op        = v.inst[1:0];
    cond      = v.cond;
    status    = v.status;
    mem_ready = v.rdy;
    exp_q.push_back(v.exp);
    tag_q.push_back(v.tag);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic cyc(input logic rst, input logic [4:0] inst, input logic [2:0] c,
                     input logic [2:0] st, input logic rdy, input out_t e,
                     input logic [95:0] tag);
    applyStimulus(mkv(rst, inst, c, st, rdy, e, tag));
  endtask

  initial begin
    reset = 1'b1; opcode = '0; op = '0; cond = '0; status = '0; mem_ready = 1'b0;

    // Table: reset, then one pass through each simple instruction flow.
    tbl.push_back(mkv(1, MOVI, 0, 0, 1, o_reset(),     "rst_hold"));
    tbl.push_back(mkv(0, MOVI, 0, 0, 1, o_reset(),     "rst_state"));
    tbl.push_back(mkv(0, MOVI, 0, 0, 1, o_if(1),       "if_movi"));
    tbl.push_back(mkv(0, MOVI, 0, 0, 1, o_upc(),       "upc_movi"));
    tbl.push_back(mkv(0, MOVI, 0, 0, 1, o_movi(),      "dec_movi"));
    tbl.push_back(mkv(0, MOVR, 0, 0, 1, o_if(1),       "if_movr"));
    tbl.push_back(mkv(0, MOVR, 0, 0, 0, o_upc(),       "upc_movr"));
    tbl.push_back(mkv(0, MOVR, 0, 0, 0, o_movr_dec(),  "dec_movr"));
    tbl.push_back(mkv(0, MOVR, 0, 0, 0, o_exec_asel(), "exec_movr"));
    tbl.push_back(mkv(0, MOVR, 0, 0, 0, o_write(),     "wr_movr"));
    tbl.push_back(mkv(0, ADD,  0, 0, 1, o_if(1),       "if_add"));
    tbl.push_back(mkv(0, ADD,  0, 0, 1, o_upc(),       "upc_add"));
    tbl.push_back(mkv(0, ADD,  0, 0, 1, o_alu_dec(),   "dec_add"));
    tbl.push_back(mkv(0, ADD,  0, 0, 1, o_exec_alu(),  "exec_add"));
    tbl.push_back(mkv(0, ADD,  0, 0, 1, o_write(),     "wr_add"));
    tbl.push_back(mkv(0, CMP,  0, 0, 1, o_if(1),       "if_cmp"));
    tbl.push_back(mkv(0, CMP,  0, 0, 1, o_upc(),       "upc_cmp"));
    tbl.push_back(mkv(0, CMP,  0, 0, 1, o_alu_dec(),   "dec_cmp"));
    tbl.push_back(mkv(0, CMP,  0, 0, 1, o_exec_cmp(),  "exec_cmp"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b001, 1, o_if(1),  "if_beq1"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b001, 1, o_upc(),  "upc_beq1"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b001, 1, o_br(1),  "beq_taken"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b000, 1, o_if(1),  "if_beq0"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b000, 1, o_upc(),  "upc_beq0"));
    tbl.push_back(mkv(0, BR, 3'b001, 3'b000, 1, o_br(0),  "beq_not"));
    tbl.push_back(mkv(0, BR, 3'b010, 3'b001, 1, o_if(1),  "if_bne"));
    tbl.push_back(mkv(0, BR, 3'b010, 3'b001, 1, o_upc(),  "upc_bne"));
    tbl.push_back(mkv(0, BR, 3'b010, 3'b001, 1, o_br(0),  "bne_not"));
    tbl.push_back(mkv(0, BR, 3'b011, 3'b100, 1, o_if(1),  "if_blt"));
    tbl.push_back(mkv(0, BR, 3'b011, 3'b100, 1, o_upc(),  "upc_blt"));
    tbl.push_back(mkv(0, BR, 3'b011, 3'b100, 1, o_br(1),  "blt_taken"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b111, 1, o_if(1),  "if_ble"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b111, 1, o_upc(),  "upc_ble"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b111, 1, o_br(1),  "ble_taken"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b110, 1, o_if(1),  "if_ble0"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b110, 1, o_upc(),  "upc_ble0"));
    tbl.push_back(mkv(0, BR, 3'b100, 3'b110, 1, o_br(0),  "ble_not"));
    tbl.push_back(mkv(0, BR, 3'b000, 3'b000, 1, o_if(1),  "if_b"));
    tbl.push_back(mkv(0, BR, 3'b000, 3'b000, 1, o_upc(),  "upc_b"));
    tbl.push_back(mkv(0, BR, 3'b000, 3'b000, 1, o_br(1),  "b_always"));
    tbl.push_back(mkv(0, BL,   0, 0, 1, o_if(1),     "if_bl"));
    tbl.push_back(mkv(0, BL,   0, 0, 1, o_upc(),     "upc_bl"));
    tbl.push_back(mkv(0, BL,   0, 0, 1, o_bl(),      "dec_bl"));

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    // A fetch with three wait cycles, followed by an LDR with two MEM wait cycles.
    for (int i = 0; i < 3; i++) cyc(0, LDR, 0, 0, 0, o_if(0), "if_wait");
    cyc(0, LDR, 0, 0, 1, o_if(1),       "if_done");
    cyc(0, LDR, 0, 0, 0, o_upc(),       "upc_ldr");
    cyc(0, LDR, 0, 0, 0, o_ldr_dec(),   "dec_ldr");
    cyc(0, LDR, 0, 0, 1, o_exec_ldr(),  "exec_ldr");
    cyc(0, LDR, 0, 0, 0, o_mem_ldr(0),  "mem_ldr_w1");
    cyc(0, LDR, 0, 0, 0, o_mem_ldr(0),  "mem_ldr_w2");
    cyc(0, LDR, 0, 0, 1, o_mem_ldr(1),  "mem_ldr_end");

    // STR keeps the write command asserted until memory responds.
    cyc(0, STR, 0, 0, 1, o_if(1),       "if_str");
    cyc(0, STR, 0, 0, 1, o_upc(),       "upc_str");
    cyc(0, STR, 0, 0, 1, o_str_dec(),   "dec_str");
    cyc(0, STR, 0, 0, 1, o_exec_str(),  "exec_str");
    cyc(0, STR, 0, 0, 0, o_mem_str(),   "mem_str_w1");
    cyc(0, STR, 0, 0, 0, o_mem_str(),   "mem_str_w2");
    cyc(0, STR, 0, 0, 1, o_mem_str(),   "mem_str_end");

    // BX and BLX go through EXEC and then BRANCH.
    cyc(0, BX,  0, 0, 1, o_if(1),       "if_bx");
    cyc(0, BX,  0, 0, 1, o_upc(),       "upc_bx");
    cyc(0, BX,  0, 0, 1, o_bx_dec(),    "dec_bx");
    cyc(0, BX,  0, 0, 1, o_exec_asel(), "exec_bx");
    cyc(0, BX,  0, 0, 1, o_branch(),    "branch_bx");
    cyc(0, BLX, 0, 0, 1, o_if(1),       "if_blx");
    cyc(0, BLX, 0, 0, 1, o_upc(),       "upc_blx");
    cyc(0, BLX, 0, 0, 1, o_blx_dec(),   "dec_blx");
    cyc(0, BLX, 0, 0, 1, o_exec_asel(), "exec_blx");
    cyc(0, BLX, 0, 0, 1, o_branch(),    "branch_blx");

    // An undefined branch condition sets illegal and halts until reset.
    cyc(0, BR, 3'b101, 0, 1, o_if(1),       "if_badc");
    cyc(0, BR, 3'b101, 0, 1, o_upc(),       "upc_badc");
    cyc(0, BR, 3'b101, 0, 1, o_none(),      "dec_badc");
    cyc(0, BR, 3'b101, 0, 1, o_halt(1, 0),  "halt_badc1");
    cyc(0, MOVI, 0,    0, 0, o_halt(1, 0),  "halt_badc2");
    cyc(1, MOVI, 0,    0, 1, o_halt(1, 0),  "halt_rst");
    cyc(0, UND,  0,    0, 1, o_reset(),     "rst_clear");

    // Opcode 000 is undefined.
    cyc(0, UND, 0, 0, 1, o_if(1),      "if_und");
    cyc(0, UND, 0, 0, 1, o_upc(),      "upc_und");
    cyc(0, UND, 0, 0, 1, o_none(),     "dec_und");
    cyc(0, UND, 0, 0, 1, o_halt(1, 0), "halt_und1");
    cyc(0, UND, 0, 0, 1, o_halt(1, 0), "halt_und2");
    cyc(1, HLT, 0, 0, 1, o_halt(1, 0), "halt_rst2");
    cyc(0, HLT, 0, 0, 1, o_reset(),    "rst_clear2");

    // HALT instruction: the block halts without setting illegal.
    cyc(0, HLT, 0, 0, 1, o_if(1),      "if_hlt");
    cyc(0, HLT, 0, 0, 1, o_upc(),      "upc_hlt");
    cyc(0, HLT, 0, 0, 1, o_none(),     "dec_hlt");
    cyc(0, HLT, 0, 0, 1, o_halt(0, 0), "halt_hlt");
    cyc(1, HLT, 0, 0, 1, o_halt(0, 0), "halt_rst3");
    cyc(0, MOVI, 0, 0, 0, o_reset(),   "rst_3");

    // Reset asserted in the middle of a fetch wait abandons the access.
    cyc(0, MOVI, 0, 0, 0, o_if(0),     "if_mid");
    cyc(1, MOVI, 0, 0, 0, o_if(0),     "if_mid_rst");
    cyc(0, MOVI, 0, 0, 0, o_reset(),   "rst_mid");

`ifdef MEM_TIMEOUT_EN
    // With the timeout enabled, four wait cycles in IF raise mem_err and halt.
    for (int i = 0; i < 4; i++) cyc(0, MOVI, 0, 0, 0, o_if(0), "if_to_wait");
    cyc(0, MOVI, 0, 0, 0, o_halt(0, 1), "halt_tmo");
    cyc(0, MOVI, 0, 0, 1, o_halt(0, 1), "halt_tmo2");
    cyc(1, MOVI, 0, 0, 1, o_halt(0, 1), "halt_tmo_r");
    cyc(0, MOVI, 0, 0, 1, o_reset(),    "rst_tmo");
`else
    // Without the timeout, a long wait stays in IF and mem_err remains 0.
    for (int i = 0; i < 12; i++) cyc(0, MOVI, 0, 0, 0, o_if(0), "if_long");
    cyc(0, MOVI, 0, 0, 1, o_if(1), "if_long_end");
    cyc(0, MOVI, 0, 0, 1, o_upc(), "upc_long");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
